// File: rtl/rng_pkg.sv
// Shared constants and helpers for the multi-lane Galois LFSR stream generator.
package rng_pkg;

    localparam logic [31:0] TAPS = 32'h80200003;

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_READY  = 1'b1
    } rng_state_t;

    // Each lane gets a distinct, well-spread base seed.
    function automatic logic [31:0] lane_seed(input int unsigned idx);
        logic [31:0] n;
        n = 32'(idx) + 32'd1;
        return n * 32'h0FE1910D;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/rng_stream_lfsr_lane.sv
// One 32-bit Galois LFSR lane with a load port that can never leave it all-zero.
module lfsr_lane
    import rng_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] state
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            // All-zero is the LFSR's lock-up state, so substitute 1.
            state_d = (load_val == 32'h0) ? 32'h0000_0001 : load_val;
        end else if (step) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/rng_stream.sv
// Streaming PRNG: WIDTH LFSR lanes, one bit each per word, with reseed and warm-up discard.
module rng_stream
    import rng_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int LFSR_LEN = 32,
    parameter int WARMUP   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_write,
    input  logic [31:0]      seed_in,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             dbg_state
);

    if (LFSR_LEN != 32) begin : g_bad_len
        $error("rng_stream: LFSR_LEN must be 32");
    end

    localparam int CW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam logic [CW-1:0] LAST = CW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam rng_state_t RST_STATE = (WARMUP == 0) ? ST_READY : ST_WARMUP;

    rng_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          step;

    // Handshake: a word transfers on any edge where out_valid && out_ready are both
    // high; out_valid never drops without a transfer except on reseed, and a
    // coincident seed_write cancels the transfer (no step, word not consumed).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step    = 1'b0;
        if (seed_write) begin
            state_d = RST_STATE;
            cnt_d   = '0;
        end else if (state_q == ST_WARMUP) begin
            step = 1'b1;
            if (cnt_q == LAST) begin
                state_d = ST_READY;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (out_ready) begin
            step = 1'b1;
        end
        valid_d = (state_d == ST_READY);
        busy_d  = (state_d == ST_WARMUP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            valid_q <= (RST_STATE == ST_READY);
            busy_q  <= (RST_STATE == ST_WARMUP);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic [31:0] lane_state;

        lfsr_lane #(
            .RESET_VAL(lane_seed(i))
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .step    (step),
            .load    (seed_write),
            .load_val(lane_seed(i) ^ seed_in),
            .state   (lane_state)
        );

        assign out_data[i] = lane_state[0];
    end

    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule
